// File: rtl/cg_pkg.sv
// Shared definitions for the conjugate-gradient iteration sequencer.
package cg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RR,
    S_MXV,
    S_ALPHA,
    S_UPD,
    S_RNEW,
    S_CHECK,
    S_BETA,
    S_PUPD,
    S_DONE
  } cg_state_e;

  localparam logic [31:0] DEFAULT_TOLERANCE = 32'h283424DC;

  // Ceiling log2; exact for the power-of-two unit counts used here.
  function automatic int unsigned cg_log2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cg_chunk_feeder.sv
// Issues chunk-read strobes for one feed phase; gated by stage readiness or free-running every other cycle.
module cg_chunk_feeder
  import cg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        active,
  input  logic        gated,
  input  logic        stage_ready,
  input  logic [31:0] num_chunks,
  output logic        chunk_read,
  output logic [31:0] chunk_index,
  output logic        done_c
);

  logic        pending_q, pending_d;
  logic        read_q, read_d;
  logic [31:0] index_q, index_d;
  logic        fire_c;

  // First strobe after entry is unconditional; later ones need an idle cycle (and readiness when gated).
  always_comb begin
    pending_d = pending_q;
    read_d    = 1'b0;
    index_d   = index_q;
    fire_c    = 1'b0;
    if (clear) begin
      pending_d = 1'b1;
      index_d   = '0;
    end else if (active) begin
      pending_d = 1'b0;
      fire_c    = (index_q != num_chunks) &&
                  (pending_q || (!read_q && (!gated || stage_ready)));
      if (fire_c) begin
        read_d  = 1'b1;
        index_d = index_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      read_q    <= 1'b0;
      index_q   <= '0;
    end else begin
      pending_q <= pending_d;
      read_q    <= read_d;
      index_q   <= index_d;
    end
  end

  assign chunk_read  = read_q;
  assign chunk_index = index_q;
  assign done_c      = active && !pending_q && (index_q == num_chunks);

endmodule

// File: rtl/cg_iteration_sequencer.sv
// Central FSM sequencing one conjugate-gradient solve: stage holds, start strobes,
// shared chunk feeder, iteration count and tolerance/timeout exit.
module cg_iteration_sequencer
  import cg_pkg::*;
#(
  parameter int unsigned element_width = 32,
  parameter int unsigned no_of_units   = 8,
  parameter int unsigned iter_width    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [31:0]              total,
  input  logic [iter_width-1:0]    max_iter,
  input  logic [element_width-1:0] tolerance,
  input  logic                     stage_ready,
  input  logic                     vXv1_finish,
  input  logic                     mXv1_finish,
  input  logic                     div1_finish,
  input  logic                     mul_add1_finish,
  input  logic                     mul_add2_finish,
  input  logic                     vXv3_finish,
  input  logic                     div2_finish,
  input  logic                     mul_add3_finish,
  input  logic [element_width-1:0] vXv3_result,
  output logic                     reset_vXv1,
  output logic                     reset_mXv1,
  output logic                     start_mul_add,
  output logic                     start_vXv3,
  output logic                     start_div2,
  output logic                     mul_add3_start,
  output logic                     chunk_read,
  output logic [31:0]              chunk_index,
  output logic [iter_width-1:0]    iteration,
  output logic                     busy,
  output logic                     finish_all,
  output logic                     converged,
  output logic                     timeout
);

  localparam int unsigned CHUNK_SHIFT = cg_log2(no_of_units);
  localparam logic [element_width-1:0] MAG_MASK = {1'b0, {(element_width-1){1'b1}}};

  cg_state_e                state_q, state_d;
  logic [iter_width-1:0]    iteration_q, iteration_d;
  logic [element_width-1:0] rnew_q, rnew_d;
  logic                     fin_seen_q, fin_seen_d;
  logic                     ma1_seen_q, ma1_seen_d;
  logic                     ma2_seen_q, ma2_seen_d;
  logic                     converged_q, converged_d;
  logic                     timeout_q, timeout_d;
  logic                     reset_vxv1_q, reset_vxv1_d;
  logic                     reset_mxv1_q, reset_mxv1_d;
  logic                     start_mul_add_q, start_mul_add_d;
  logic                     start_vxv3_q, start_vxv3_d;
  logic                     start_div2_q, start_div2_d;
  logic                     mul_add3_start_q, mul_add3_start_d;
  logic                     busy_q, busy_d;
  logic                     finish_all_q, finish_all_d;

  logic [31:0] num_chunks;
  logic        feed_enter_c, feed_active_c, feed_done_c, rnew_small_c;

  assign num_chunks    = total >> CHUNK_SHIFT;
  assign feed_active_c = (state_q == S_RR) || (state_q == S_RNEW);
  assign feed_enter_c  = ((state_d == S_RR) || (state_d == S_RNEW)) && (state_d != state_q);
  // Positive and magnitude within tolerance, compared as unsigned bit patterns.
  assign rnew_small_c  = !rnew_q[element_width-1] && ((rnew_q & MAG_MASK) <= (tolerance & MAG_MASK));

  cg_chunk_feeder u_feeder (
    .clk         (clk),
    .reset       (reset),
    .clear       (feed_enter_c),
    .active      (feed_active_c),
    .gated       (state_q == S_RR),
    .stage_ready (stage_ready),
    .num_chunks  (num_chunks),
    .chunk_read  (chunk_read),
    .chunk_index (chunk_index),
    .done_c      (feed_done_c)
  );

  always_comb begin
    state_d     = state_q;
    iteration_d = iteration_q;
    rnew_d      = rnew_q;
    fin_seen_d  = fin_seen_q;
    ma1_seen_d  = ma1_seen_q;
    ma2_seen_d  = ma2_seen_q;
    converged_d = converged_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          iteration_d = '0;
          converged_d = 1'b0;
          timeout_d   = 1'b0;
          if (max_iter == '0) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else begin
            state_d = S_RR;
          end
        end
      end
      S_RR: begin
        if (vXv1_finish) fin_seen_d = 1'b1;
        if ((fin_seen_q || vXv1_finish) && feed_done_c) state_d = S_MXV;
      end
      S_MXV:   if (mXv1_finish) state_d = S_ALPHA;
      S_ALPHA: if (div1_finish) state_d = S_UPD;
      S_UPD: begin
        if (mul_add1_finish) ma1_seen_d = 1'b1;
        if (mul_add2_finish) ma2_seen_d = 1'b1;
        if ((ma1_seen_q || mul_add1_finish) && (ma2_seen_q || mul_add2_finish)) state_d = S_RNEW;
      end
      S_RNEW: begin
        if (vXv3_finish) begin
          fin_seen_d = 1'b1;
          rnew_d     = vXv3_result;
        end
        if ((fin_seen_q || vXv3_finish) && feed_done_c) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (rnew_small_c) begin
          state_d     = S_DONE;
          converged_d = 1'b1;
        end else begin
          state_d = S_BETA;
        end
      end
      S_BETA: if (div2_finish) state_d = S_PUPD;
      S_PUPD: begin
        if (mul_add3_finish) begin
          iteration_d = iteration_q + iter_width'(1);
          if (iteration_d == max_iter) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else begin
            state_d = S_RR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Per-state finish memory starts fresh on every transition.
    if (state_d != state_q) begin
      fin_seen_d = 1'b0;
      ma1_seen_d = 1'b0;
      ma2_seen_d = 1'b0;
    end

    reset_vxv1_d     = !(state_d inside {S_RR, S_MXV, S_ALPHA});
    reset_mxv1_d     = !(state_d inside {S_MXV, S_ALPHA});
    start_mul_add_d  = state_d inside {S_UPD, S_RNEW, S_CHECK, S_BETA, S_PUPD};
    start_vxv3_d     = (state_d == S_RNEW);
    start_div2_d     = (state_d == S_BETA) && (state_q != S_BETA);
    mul_add3_start_d = (state_d == S_PUPD) && (state_q != S_PUPD);
    busy_d           = !(state_d inside {S_IDLE, S_DONE});
    finish_all_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      iteration_q      <= '0;
      rnew_q           <= '0;
      fin_seen_q       <= 1'b0;
      ma1_seen_q       <= 1'b0;
      ma2_seen_q       <= 1'b0;
      converged_q      <= 1'b0;
      timeout_q        <= 1'b0;
      reset_vxv1_q     <= 1'b1;
      reset_mxv1_q     <= 1'b1;
      start_mul_add_q  <= 1'b0;
      start_vxv3_q     <= 1'b0;
      start_div2_q     <= 1'b0;
      mul_add3_start_q <= 1'b0;
      busy_q           <= 1'b0;
      finish_all_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      iteration_q      <= iteration_d;
      rnew_q           <= rnew_d;
      fin_seen_q       <= fin_seen_d;
      ma1_seen_q       <= ma1_seen_d;
      ma2_seen_q       <= ma2_seen_d;
      converged_q      <= converged_d;
      timeout_q        <= timeout_d;
      reset_vxv1_q     <= reset_vxv1_d;
      reset_mxv1_q     <= reset_mxv1_d;
      start_mul_add_q  <= start_mul_add_d;
      start_vxv3_q     <= start_vxv3_d;
      start_div2_q     <= start_div2_d;
      mul_add3_start_q <= mul_add3_start_d;
      busy_q           <= busy_d;
      finish_all_q     <= finish_all_d;
    end
  end

  assign reset_vXv1     = reset_vxv1_q;
  assign reset_mXv1     = reset_mxv1_q;
  assign start_mul_add  = start_mul_add_q;
  assign start_vXv3     = start_vxv3_q;
  assign start_div2     = start_div2_q;
  assign mul_add3_start = mul_add3_start_q;
  assign iteration      = iteration_q;
  assign busy           = busy_q;
  assign finish_all     = finish_all_q;
  assign converged      = converged_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Directed bench for cg_iteration_sequencer: full solves, convergence, UPD ordering,
// backpressure, mid-solve reset and degenerate inputs.
module tb_cg_iteration_sequencer;
  import cg_pkg::*;

  logic        clk = 1'b0;
  logic        reset, go, stage_ready;
  logic [31:0] total, tolerance, vXv3_result;
  logic [15:0] max_iter;
  logic        vXv1_finish, mXv1_finish, div1_finish, mul_add1_finish;
  logic        mul_add2_finish, vXv3_finish, div2_finish, mul_add3_finish;
  logic        reset_vXv1, reset_mXv1, start_mul_add, start_vXv3, start_div2, mul_add3_start;
  logic        chunk_read, busy, finish_all, converged, timeout;
  logic [31:0] chunk_index;
  logic [15:0] iteration;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt;

  always #5 clk = ~clk;

  cg_iteration_sequencer #(.element_width(32), .no_of_units(8), .iter_width(16)) dut (
    .clk(clk), .reset(reset), .go(go), .total(total), .max_iter(max_iter),
    .tolerance(tolerance), .stage_ready(stage_ready),
    .vXv1_finish(vXv1_finish), .mXv1_finish(mXv1_finish), .div1_finish(div1_finish),
    .mul_add1_finish(mul_add1_finish), .mul_add2_finish(mul_add2_finish),
    .vXv3_finish(vXv3_finish), .div2_finish(div2_finish), .mul_add3_finish(mul_add3_finish),
    .vXv3_result(vXv3_result),
    .reset_vXv1(reset_vXv1), .reset_mXv1(reset_mXv1), .start_mul_add(start_mul_add),
    .start_vXv3(start_vXv3), .start_div2(start_div2), .mul_add3_start(mul_add3_start),
    .chunk_read(chunk_read), .chunk_index(chunk_index), .iteration(iteration),
    .busy(busy), .finish_all(finish_all), .converged(converged), .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic t_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // Starts at the first RR cycle with vXv1_finish delivered early; ends at the first MXV cycle.
  task automatic t_rr(input int exp_n);
    int n;
    int i;
    n = 0;
    i = 0;
    vXv1_finish = 1'b1;
    while (reset_mXv1 && i < 50) begin
      tick();
      vXv1_finish = 1'b0;
      if (chunk_read) n++;
      i++;
    end
    chk("rr_exit_to_mxv", reset_mXv1, 0);
    chk("rr_strobes", n, exp_n);
    chk("rr_chunk_index", chunk_index, exp_n);
    chk("mxv_vxv1_released", reset_vXv1, 0);
  endtask

  // MXV -> ALPHA -> UPD, optionally poking inputs that must be ignored while in ALPHA.
  task automatic t_mxv_alpha(input bit poke);
    mXv1_finish = 1'b1;
    tick();
    mXv1_finish = 1'b0;
    if (poke) begin
      go = 1'b1;
      div2_finish = 1'b1;
      mul_add1_finish = 1'b1;
    end
    tick();
    go = 1'b0;
    div2_finish = 1'b0;
    mul_add1_finish = 1'b0;
    chk("alpha_busy", busy, 1);
    chk("alpha_mxv_released", reset_mXv1, 0);
    chk("alpha_no_mul_add", start_mul_add, 0);
    div1_finish = 1'b1;
    tick();
    div1_finish = 1'b0;
    chk("upd_start_mul_add", start_mul_add, 1);
    chk("upd_vxv1_held", reset_vXv1, 1);
    chk("upd_mxv_held", reset_mXv1, 1);
    chk("upd_no_vxv3", start_vXv3, 0);
  endtask

  task automatic t_upd_same();
    mul_add1_finish = 1'b1;
    mul_add2_finish = 1'b1;
    tick();
    mul_add1_finish = 1'b0;
    mul_add2_finish = 1'b0;
    chk("upd_same_to_rnew", start_vXv3, 1);
  endtask

  // RNEW with early finish; result changes afterwards to prove it was latched. Ends at CHECK.
  task automatic t_rnew(input logic [31:0] val, input logic [31:0] after, input int exp_n);
    int n;
    int i;
    n = 0;
    i = 0;
    vXv3_finish = 1'b1;
    vXv3_result = val;
    while (start_vXv3 && i < 50) begin
      tick();
      vXv3_finish = 1'b0;
      vXv3_result = after;
      if (chunk_read) n++;
      i++;
    end
    chk("rnew_exit_to_check", start_vXv3, 0);
    chk("rnew_strobes", n, exp_n);
    chk("rnew_chunk_index", chunk_index, exp_n);
    chk("check_mul_add_level", start_mul_add, 1);
  endtask

  // CHECK -> BETA -> PUPD -> RR/DONE for a non-converging iteration.
  task automatic t_beta_pupd(input int exp_iter);
    tick();
    chk("beta_div2_pulse", start_div2, 1);
    tick();
    chk("beta_div2_drop", start_div2, 0);
    div2_finish = 1'b1;
    tick();
    div2_finish = 1'b0;
    chk("pupd_start_pulse", mul_add3_start, 1);
    tick();
    chk("pupd_start_drop", mul_add3_start, 0);
    chk("pupd_iter_before", iteration, exp_iter - 1);
    mul_add3_finish = 1'b1;
    tick();
    mul_add3_finish = 1'b0;
    chk("pupd_iter_after", iteration, exp_iter);
    chk("pupd_mul_add_drop", start_mul_add, 0);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; stage_ready = 1'b1;
    total = 32'd16; max_iter = 16'd4; tolerance = DEFAULT_TOLERANCE; vXv3_result = '0;
    vXv1_finish = 1'b0; mXv1_finish = 1'b0; div1_finish = 1'b0; mul_add1_finish = 1'b0;
    mul_add2_finish = 1'b0; vXv3_finish = 1'b0; div2_finish = 1'b0; mul_add3_finish = 1'b0;
    tick();
    tick();
    chk("rst_reset_vxv1", reset_vXv1, 1);
    chk("rst_reset_mxv1", reset_mXv1, 1);
    chk("rst_busy", busy, 0);
    chk("rst_finish_all", finish_all, 0);
    chk("rst_chunk_read", chunk_read, 0);
    chk("rst_chunk_index", chunk_index, 0);
    chk("rst_iteration", iteration, 0);
    chk("rst_start_mul_add", start_mul_add, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Basic path: four non-converging iterations end in timeout.
    t_go();
    chk("go_busy", busy, 1);
    chk("go_vxv1_released", reset_vXv1, 0);
    chk("go_chunk_index", chunk_index, 0);
    for (int it = 1; it <= 4; it++) begin
      t_rr(2);
      t_mxv_alpha(1'b0);
      t_upd_same();
      t_rnew(32'h3F800000, 32'h00000001, 2);
      t_beta_pupd(it);
    end
    chk("basic_finish_all", finish_all, 1);
    chk("basic_timeout", timeout, 1);
    chk("basic_converged", converged, 0);
    chk("basic_busy", busy, 0);
    chk("basic_iteration", iteration, 4);
    tick();
    chk("done_hold_finish", finish_all, 1);
    chk("done_hold_timeout", timeout, 1);

    // Convergence in the second iteration, started from DONE.
    t_go();
    chk("conv_go_timeout_clr", timeout, 0);
    chk("conv_go_finish_clr", finish_all, 0);
    chk("conv_go_iter_clr", iteration, 0);
    t_rr(2);
    t_mxv_alpha(1'b0);
    t_upd_same();
    t_rnew(32'h3F800000, 32'h00000001, 2);
    t_beta_pupd(1);
    t_rr(2);
    t_mxv_alpha(1'b0);
    t_upd_same();
    t_rnew(32'h20000000, 32'h3F800000, 2);
    tick();
    chk("conv_finish_all", finish_all, 1);
    chk("conv_converged", converged, 1);
    chk("conv_timeout", timeout, 0);
    chk("conv_iteration", iteration, 1);
    chk("conv_no_div2", start_div2, 0);
    chk("conv_mul_add_drop", start_mul_add, 0);
    tick();
    chk("conv_no_div2_later", start_div2, 0);

    // Backpressure, ignored inputs in ALPHA, staggered UPD finishes, then reset in BETA.
    t_go();
    stage_ready = 1'b0;
    tick();
    chk("bp_first_strobe", chunk_read, 1);
    chk("bp_first_index", chunk_index, 1);
    cnt = 0;
    repeat (10) begin
      tick();
      if (chunk_read) cnt++;
    end
    chk("bp_no_strobe_held", cnt, 0);
    chk("bp_index_held", chunk_index, 1);
    stage_ready = 1'b1;
    tick();
    chk("bp_second_strobe", chunk_read, 1);
    chk("bp_second_index", chunk_index, 2);
    vXv1_finish = 1'b1;
    tick();
    vXv1_finish = 1'b0;
    chk("bp_late_finish_to_mxv", reset_mXv1, 0);
    t_mxv_alpha(1'b1);
    mul_add2_finish = 1'b1;
    tick();
    mul_add2_finish = 1'b0;
    tick();
    tick();
    chk("stagger_still_upd", start_vXv3, 0);
    mul_add1_finish = 1'b1;
    tick();
    mul_add1_finish = 1'b0;
    chk("stagger_to_rnew", start_vXv3, 1);
    t_rnew(32'h3F800000, 32'h00000001, 2);
    t_beta_pupd(1);
    t_rr(2);
    t_mxv_alpha(1'b0);
    t_upd_same();
    t_rnew(32'h3F800000, 32'h00000001, 2);
    tick();
    chk("beta_entry_div2", start_div2, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_reset_vxv1", reset_vXv1, 1);
    chk("midrst_reset_mxv1", reset_mXv1, 1);
    chk("midrst_start_div2", start_div2, 0);
    chk("midrst_start_mul_add", start_mul_add, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_iteration", iteration, 0);
    chk("midrst_chunk_index", chunk_index, 0);
    div2_finish = 1'b1;
    tick();
    div2_finish = 1'b0;
    tick();
    chk("stray_div2_busy", busy, 0);
    chk("stray_div2_pupd", mul_add3_start, 0);
    chk("stray_div2_finish_all", finish_all, 0);
    chk("stray_div2_vxv1", reset_vXv1, 1);

    // max_iter = 0 goes straight to DONE with no stage activity.
    max_iter = 16'd0;
    t_go();
    chk("mi0_finish_all", finish_all, 1);
    chk("mi0_timeout", timeout, 1);
    chk("mi0_busy", busy, 0);
    chk("mi0_reset_vxv1", reset_vXv1, 1);
    chk("mi0_reset_mxv1", reset_mXv1, 1);
    cnt = 0;
    repeat (5) begin
      tick();
      if (chunk_read || start_mul_add || !reset_vXv1) cnt++;
    end
    chk("mi0_no_activity", cnt, 0);

    // total = 0: no strobes, FSM still advances on finish pulses.
    total = 32'd0;
    max_iter = 16'd1;
    t_go();
    t_rr(0);
    t_mxv_alpha(1'b0);
    t_upd_same();
    t_rnew(32'h3F800000, 32'h00000001, 0);
    t_beta_pupd(1);
    chk("t0_finish_all", finish_all, 1);
    chk("t0_timeout", timeout, 1);
    chk("t0_converged", converged, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
